// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: instruction classes, FSM
// state/stage encodings and the per-class strobe decode.
package multicycle_ctrl_pkg;

    localparam int CLASS_W = 5;

    typedef enum logic [CLASS_W-1:0] {
        CL_NONE = 5'd0,
        RTYPE   = 5'd1,
        ITYPE   = 5'd2,
        STYPE   = 5'd3,
        BTYPE   = 5'd4,
        UTYPE   = 5'd5,
        LTYPE   = 5'd6,
        JTYPE   = 5'd7,
        JRTYPE  = 5'd8,
        UPCTYPE = 5'd9
    } iclass_e;

    // State codes double as the externally visible stage number.
    typedef enum logic [2:0] {
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_FAULT   = 3'd7
    } state_e;

    typedef struct packed {
        logic rd_a;
        logic rd_b;
        logic pass;
    } strobes_t;

    function automatic strobes_t decode_strobes(input iclass_e c);
        strobes_t s;
        s = '0;
        case (c)
            RTYPE, ITYPE, LTYPE: s = '{rd_a: 1'b1, rd_b: 1'b1, pass: 1'b0};
            STYPE, BTYPE:        s = '{rd_a: 1'b1, rd_b: 1'b1, pass: 1'b1};
            UTYPE, JRTYPE:       s = '{rd_a: 1'b1, rd_b: 1'b0, pass: 1'b0};
            default:             s = '0;
        endcase
        return s;
    endfunction

    function automatic logic writes_rd(input iclass_e c);
        case (c)
            RTYPE, ITYPE, UTYPE, LTYPE, UPCTYPE, JTYPE, JRTYPE: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Bus wait-state counter: counts cycles a request has been stalled and flags
// the cycle in which the stall reaches MEM_TIMEOUT (0 disables the timeout).
module ctrl_wait_timer #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    output logic timeout_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] LIMIT   = TIMEOUT_W'(MEM_TIMEOUT);
    localparam bit ENABLED = (MEM_TIMEOUT != 0) && (MEM_TIMEOUT <= (2**TIMEOUT_W - 1));

    logic [TIMEOUT_W-1:0] count_q, count_d;

    // NOTE: combinational blocks assign every output first so no path leaves a latch.
    always_comb begin
        count_d = '0;
        if (wait_i) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + TIMEOUT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = ENABLED && wait_i && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-stage multicycle controller with req/ready memory handshake and sticky
// bus-timeout fault. Define CTRL_PERF_EN to build the cycle/instret counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ITYPE_W     = 5,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic [2:0]         stage_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic               mem_ready_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic               pc_wen_o,
    input  logic [XLEN-1:0]    alu_addr_i,
    input  logic [XLEN-1:0]    store_data_i,
    input  logic [ITYPE_W-1:0] itype_i,
    output logic [XLEN-1:0]    ir_o,
    output logic [XLEN-1:0]    load_data_o,
    output logic               rd_a_o,
    output logic               rd_b_o,
    output logic               pass_o,
    output logic               wb_q_readin_o,
    output logic               wb_en_o,
    output logic               fault_o,
    output logic [XLEN-1:0]    cycle_cnt_o,
    output logic [XLEN-1:0]    instret_o
);

    function automatic iclass_e to_class(input logic [ITYPE_W-1:0] code);
        logic [31:0] code32;
        code32 = 32'(code);
        if (code32 >= 32'(RTYPE) && code32 <= 32'(UPCTYPE)) begin
            return iclass_e'(code32[CLASS_W-1:0]);
        end
        return CL_NONE;
    endfunction

    state_e          state_q, state_d;
    logic            run_q;
    logic [XLEN-1:0] ir_q, ir_d, load_q, load_d;
    iclass_e         cls;
    strobes_t        stb;
    logic            mem_req, mem_we, wb_readin, wb_en, pc_wen;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            timeout;

    assign cls = to_class(itype_i);

    // run_q keeps the bus quiet for the first cycle after reset, so a reset
    // never leaves a request dangling towards memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            ir_q    <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            ir_q    <= ir_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        load_d    = load_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stb       = '0;
        wb_readin = 1'b0;
        wb_en     = 1'b0;
        pc_wen    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_i;
                    if (mem_ready_i) begin
                        ir_d    = mem_rdata_i;
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_DECODE: begin
                stb     = decode_strobes(cls);
                state_d = S_EXECUTE;
            end
            S_EXECUTE: state_d = S_MEM;
            S_MEM: begin
                if (cls == STYPE || cls == LTYPE) begin
                    mem_req   = 1'b1;
                    mem_we    = (cls == STYPE);
                    mem_addr  = alu_addr_i;
                    mem_wdata = (cls == STYPE) ? store_data_i : '0;
                    if (mem_ready_i) begin
                        wb_readin = (cls == LTYPE);
                        if (cls == LTYPE) load_d = mem_rdata_i;
                        state_d = S_WB;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end else begin
                    wb_readin = writes_rd(cls);
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                wb_en   = writes_rd(cls);
                pc_wen  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    ctrl_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .wait_i    (mem_req && !mem_ready_i),
        .timeout_o (timeout)
    );

    assign stage_o       = state_q;
    assign mem_req_o     = mem_req;
    assign mem_we_o      = mem_we;
    assign mem_addr_o    = mem_addr;
    assign mem_wdata_o   = mem_wdata;
    assign pc_wen_o      = pc_wen;
    assign ir_o          = ir_q;
    assign load_data_o   = load_q;
    assign rd_a_o        = stb.rd_a;
    assign rd_b_o        = stb.rd_b;
    assign pass_o        = stb.pass;
    assign wb_q_readin_o = wb_readin;
    assign wb_en_o       = wb_en;
    assign fault_o       = (state_q == S_FAULT);

`ifdef CTRL_PERF_EN
    logic [XLEN-1:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (run_q && state_q != S_FAULT) cycle_q <= cycle_q + XLEN'(1);
            if (pc_wen) instret_q <= instret_q + XLEN'(1);
        end
    end

    assign cycle_cnt_o = cycle_q;
    assign instret_o   = instret_q;
`else
    assign cycle_cnt_o = '0;
    assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table for the
// strobe/stage sequence plus directed handshake, timeout and reset sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_ready_i;
    logic [31:0] pc_i;
    logic        pc_wen_o;
    logic [31:0] alu_addr_i, store_data_i;
    logic [4:0]  itype_i;
    logic [31:0] ir_o, load_data_o;
    logic        rd_a_o, rd_b_o, pass_o, wb_q_readin_o, wb_en_o, fault_o;
    logic [31:0] cycle_cnt_o, instret_o;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stage_o       (stage_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ready_i   (mem_ready_i),
        .pc_i          (pc_i),
        .pc_wen_o      (pc_wen_o),
        .alu_addr_i    (alu_addr_i),
        .store_data_i  (store_data_i),
        .itype_i       (itype_i),
        .ir_o          (ir_o),
        .load_data_o   (load_data_o),
        .rd_a_o        (rd_a_o),
        .rd_b_o        (rd_b_o),
        .pass_o        (pass_o),
        .wb_q_readin_o (wb_q_readin_o),
        .wb_en_o       (wb_en_o),
        .fault_o       (fault_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_o     (instret_o)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] C_R = 5'd1, C_S = 5'd3, C_B = 5'd4, C_U = 5'd5, C_L = 5'd6;
    localparam logic [4:0] C_JR = 5'd8, C_UPC = 5'd9, C_UNK = 5'd31;

    // flags: {req, we, rd_a, rd_b, pass, wb_q_readin, wb_en, pc_wen}
    typedef struct {
        logic [4:0] itype;
        logic [2:0] stage;
        logic [7:0] flags;
    } vec_t;

    vec_t vecs[30];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          r_cycles, r_wb, r_pc, r_we, r_unstable;
    logic        r_done;
    logic [31:0] r_fetch_addr, r_mem_addr, r_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH to the following FETCH, inserting the
    // requested wait states on each bus request.
    task automatic run_instr(input logic [4:0] cls, input int fw, input int mw,
                             input logic [31:0] f_data, input logic [31:0] m_data);
        int waited;
        logic [64:0] first_bus;
        r_cycles = 0; r_wb = 0; r_pc = 0; r_we = 0; r_unstable = 0; r_done = 1'b0;
        r_fetch_addr = '0; r_mem_addr = '0; r_wdata = '0;
        waited = 0;
        first_bus = '0;
        itype_i = cls;
        for (int k = 0; k < 200; k++) begin
            int need;
            mem_ready_i = 1'b0;
            mem_rdata_i = '0;
            #1;
            if (mem_req_o) begin
                need = (stage_o == 3'd1) ? fw : mw;
                if (waited == 0) first_bus = {mem_we_o, mem_addr_o, mem_wdata_o};
                else if ({mem_we_o, mem_addr_o, mem_wdata_o} != first_bus) r_unstable++;
                if (stage_o == 3'd1) r_fetch_addr = mem_addr_o;
                else r_mem_addr = mem_addr_o;
                if (mem_we_o) begin
                    r_we++;
                    r_wdata = mem_wdata_o;
                end
                if (waited >= need) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = (stage_o == 3'd1) ? f_data : m_data;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            r_wb += int'(wb_en_o);
            r_pc += int'(pc_wen_o);
            r_cycles++;
            r_done = pc_wen_o;
            step();
            if (r_done) break;
        end
        mem_ready_i = 1'b0;
        check("instr_completes", 64'(r_done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cyc, exp_ret;

        vecs[0]  = '{C_R,   3'd1, 8'b1000_0000};
        vecs[1]  = '{C_R,   3'd2, 8'b0011_0000};
        vecs[2]  = '{C_R,   3'd3, 8'b0000_0000};
        vecs[3]  = '{C_R,   3'd4, 8'b0000_0100};
        vecs[4]  = '{C_R,   3'd5, 8'b0000_0011};
        vecs[5]  = '{C_B,   3'd1, 8'b1000_0000};
        vecs[6]  = '{C_B,   3'd2, 8'b0011_1000};
        vecs[7]  = '{C_B,   3'd3, 8'b0000_0000};
        vecs[8]  = '{C_B,   3'd4, 8'b0000_0000};
        vecs[9]  = '{C_B,   3'd5, 8'b0000_0001};
        vecs[10] = '{C_U,   3'd1, 8'b1000_0000};
        vecs[11] = '{C_U,   3'd2, 8'b0010_0000};
        vecs[12] = '{C_U,   3'd3, 8'b0000_0000};
        vecs[13] = '{C_U,   3'd4, 8'b0000_0100};
        vecs[14] = '{C_U,   3'd5, 8'b0000_0011};
        vecs[15] = '{C_JR,  3'd1, 8'b1000_0000};
        vecs[16] = '{C_JR,  3'd2, 8'b0010_0000};
        vecs[17] = '{C_JR,  3'd3, 8'b0000_0000};
        vecs[18] = '{C_JR,  3'd4, 8'b0000_0100};
        vecs[19] = '{C_JR,  3'd5, 8'b0000_0011};
        vecs[20] = '{C_UPC, 3'd1, 8'b1000_0000};
        vecs[21] = '{C_UPC, 3'd2, 8'b0000_0000};
        vecs[22] = '{C_UPC, 3'd3, 8'b0000_0000};
        vecs[23] = '{C_UPC, 3'd4, 8'b0000_0100};
        vecs[24] = '{C_UPC, 3'd5, 8'b0000_0011};
        vecs[25] = '{C_UNK, 3'd1, 8'b1000_0000};
        vecs[26] = '{C_UNK, 3'd2, 8'b0000_0000};
        vecs[27] = '{C_UNK, 3'd3, 8'b0000_0000};
        vecs[28] = '{C_UNK, 3'd4, 8'b0000_0000};
        vecs[29] = '{C_UNK, 3'd5, 8'b0000_0001};

        reset = 1'b0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        pc_i = 32'h40; alu_addr_i = '0; store_data_i = '0; itype_i = C_R;
        repeat (2) step();

        check("rst_stage", 64'(stage_o), 64'd1);
        check("rst_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
        check("rst_ir_load", {ir_o, load_data_o}, 64'd0);
        check("rst_strobes_fault", {rd_a_o, rd_b_o, pass_o, wb_q_readin_o, wb_en_o, pc_wen_o, fault_o}, 64'd0);
        check("rst_perf", {cycle_cnt_o, instret_o}, 64'd0);

        reset = 1'b1;
        step();

        // Ready held high everywhere: it must be ignored outside requests.
        for (int i = 0; i < 30; i++) begin
            itype_i = vecs[i].itype;
            mem_ready_i = 1'b1;
            mem_rdata_i = 32'h0000_0033;
            #1;
            check($sformatf("vec%0d", i),
                  {stage_o, mem_req_o, mem_we_o, rd_a_o, rd_b_o, pass_o, wb_q_readin_o, wb_en_o, pc_wen_o},
                  {vecs[i].stage, vecs[i].flags});
            step();
        end

        pc_i = 32'h40;
        run_instr(C_R, 0, 0, 32'h0020_81B3, '0);
        check("add_cycles", 64'(r_cycles), 64'd5);
        check("add_pulses", {32'(r_wb), 32'(r_pc)}, {32'd1, 32'd1});
        check("add_fetch_addr", 64'(r_fetch_addr), 64'h40);
        check("add_ir", 64'(ir_o), 64'h0020_81B3);

        pc_i = 32'h80; alu_addr_i = 32'h200;
        run_instr(C_L, 3, 2, 32'h0000_2283, 32'hDEAD_BEEF);
        check("lw_cycles", 64'(r_cycles), 64'd10);
        check("lw_load_data", 64'(load_data_o), 64'hDEAD_BEEF);
        check("lw_ir", 64'(ir_o), 64'h0000_2283);
        check("lw_addr", {r_fetch_addr, r_mem_addr}, {32'h80, 32'h200});
        check("lw_stable", 64'(r_unstable), 64'd0);
        check("lw_wb", 64'(r_wb), 64'd1);

        alu_addr_i = 32'h100; store_data_i = 32'h1234_5678;
        run_instr(C_S, 0, 0, 32'h0000_2023, '0);
        check("sw_cycles", 64'(r_cycles), 64'd5);
        check("sw_we_count", 64'(r_we), 64'd1);
        check("sw_addr_wdata", {r_mem_addr, r_wdata}, {32'h100, 32'h1234_5678});
        check("sw_no_wb", 64'(r_wb), 64'd0);
        check("sw_load_kept", 64'(load_data_o), 64'hDEAD_BEEF);

        // Ready on the 16th request cycle wins over the timeout.
        run_instr(C_R, 15, 0, 32'h1, '0);
        check("late_ready_cycles", 64'(r_cycles), 64'd20);
        check("late_ready_no_fault", {61'd0, stage_o, fault_o}, {61'd0, 3'd1, 1'b0});

        // Reset in the middle of a load's memory wait.
        itype_i = C_L; alu_addr_i = 32'h300;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_2283;
        repeat (3) step();
        mem_ready_i = 1'b0;
        #1;
        check("midmem_in_mem", {62'd0, stage_o == 3'd4, mem_req_o}, 64'd3);
        step();
        reset = 1'b0;
        step();
        check("midmem_rst_stage", 64'(stage_o), 64'd1);
        check("midmem_rst_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
        check("midmem_rst_regs", {ir_o, load_data_o}, 64'd0);
        check("midmem_rst_strobes", {rd_a_o, rd_b_o, pass_o, wb_q_readin_o, wb_en_o, pc_wen_o, fault_o}, 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) run_instr(C_R, 0, 0, 32'h33, '0);
`ifdef CTRL_PERF_EN
        exp_cyc = 32'd20; exp_ret = 32'd4;
`else
        exp_cyc = 32'd0;  exp_ret = 32'd0;
`endif
        check("perf_4_instr", {cycle_cnt_o, instret_o}, {exp_cyc, exp_ret});

        // Bus never ready: fault after exactly 16 request cycles.
        itype_i = C_R; mem_ready_i = 1'b0;
        repeat (15) step();
        check("timeout_cycle16_still_fetch", {62'd0, stage_o == 3'd1, mem_req_o}, 64'd3);
        step();
        check("timeout_fault", {59'd0, stage_o, mem_req_o, fault_o}, {59'd0, 3'd7, 1'b0, 1'b1});
        mem_ready_i = 1'b1;
        repeat (3) step();
        check("fault_sticky", {60'd0, stage_o, fault_o}, {60'd0, 3'd7, 1'b1});
`ifdef CTRL_PERF_EN
        exp_cyc = 32'd36;
`else
        exp_cyc = 32'd0;
`endif
        check("perf_frozen_in_fault", {cycle_cnt_o, instret_o}, {exp_cyc, exp_ret});
        mem_ready_i = 1'b0;
        reset = 1'b0;
        step();
        check("fault_cleared_by_reset", {60'd0, stage_o, fault_o}, {60'd0, 3'd1, 1'b0});
        reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
